// File: rtl/time_display_scan.sv
// Six-digit multiplexed HH:MM:SS scanner for an active-low 7-segment display.
// Each frame is rendered from a snapshot taken when the digit index wraps.
module time_display_scan #(
    parameter int unsigned SCAN_DIV    = 50000,
    parameter int unsigned BLINK_TICKS = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] hours,
    input  logic [5:0] minutes,
    input  logic [5:0] seconds,
    input  logic       Mode24t12,
    input  logic       EditMode,
    input  logic [2:0] EditPos,
    input  logic [1:0] screen,
    output logic [6:0] seg,
    output logic [5:0] an,
    output logic       pm,
    output logic       frame_start
);

    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned BW = $clog2(BLINK_TICKS + 1);
    localparam logic [PW-1:0] PRE_MAX   = PW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_TICKS - 1);
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    logic [PW-1:0] presc_q;
    logic [2:0]    idx_q;
    logic          started_q;
    logic [BW-1:0] blink_cnt_q;
    logic          blink_q;
    logic [4:0]    snap_h_q;
    logic [5:0]    snap_m_q, snap_s_q;
    logic          snap_mode_q, snap_edit_q;
    logic [2:0]    snap_pos_q;
    logic [1:0]    snap_scr_q;

    logic          tick, wrap;
    logic [6:0]    seg_d;
    logic [5:0]    an_d;
    logic          pm_d;

    function automatic logic [3:0] tens_of(input logic [5:0] v);
        logic [5:0] q;
        q = v / 6'd10;
        return q[3:0];
    endfunction

    function automatic logic [3:0] units_of(input logic [5:0] v);
        logic [5:0] r;
        r = v % 6'd10;
        return r[3:0];
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

    assign tick = (presc_q == PRE_MAX);
    // The very first tick after reset behaves as a wrap so a frame starts cleanly.
    assign wrap = tick && (!started_q || idx_q == 3'd5);

    always_comb begin
        logic [4:0] dh;
        logic       hour_ok, dash, blank;
        logic [3:0] hr_t, hr_u, val;

        hour_ok = (snap_h_q < 5'd24);
        dh      = snap_h_q;
        if (snap_mode_q) begin
            if (snap_h_q == 5'd0)       dh = 5'd12;
            else if (snap_h_q > 5'd12)  dh = snap_h_q - 5'd12;
        end
        hr_t  = tens_of({1'b0, dh});
        hr_u  = units_of({1'b0, dh});
        pm_d  = snap_mode_q && hour_ok && (snap_h_q >= 5'd12);

        dash  = 1'b0;
        blank = 1'b0;
        val   = 4'd0;
        case (idx_q)
            3'd0: begin
                dash  = !hour_ok;
                val   = hr_t;
                blank = hour_ok && snap_mode_q && (hr_t == 4'd0);
            end
            3'd1: begin dash = !hour_ok;             val = hr_u;               end
            3'd2: begin dash = (snap_m_q > 6'd59);   val = tens_of(snap_m_q);  end
            3'd3: begin dash = (snap_m_q > 6'd59);   val = units_of(snap_m_q); end
            3'd4: begin dash = (snap_s_q > 6'd59);   val = tens_of(snap_s_q);  end
            3'd5: begin dash = (snap_s_q > 6'd59);   val = units_of(snap_s_q); end
            default: blank = 1'b1;
        endcase

        if (snap_edit_q && blink_q &&
            (snap_pos_q == idx_q || (snap_pos_q == 3'd7 && idx_q < 3'd2)))
            blank = 1'b1;
        if (!started_q || snap_scr_q != 2'd0)
            blank = 1'b1;

        if (blank) begin
            seg_d = SEG_BLANK;
            an_d  = 6'b111111;
        end else begin
            seg_d = dash ? SEG_DASH : seg_of(val);
            an_d  = ~(6'b000001 << idx_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q     <= '0;
            idx_q       <= 3'd0;
            started_q   <= 1'b0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
            snap_h_q    <= 5'd0;
            snap_m_q    <= 6'd0;
            snap_s_q    <= 6'd0;
            snap_mode_q <= 1'b0;
            snap_edit_q <= 1'b0;
            snap_pos_q  <= 3'd0;
            snap_scr_q  <= 2'd0;
            seg         <= SEG_BLANK;
            an          <= 6'b111111;
            pm          <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            presc_q     <= tick ? '0 : presc_q + PW'(1);
            frame_start <= wrap;
            if (tick) begin
                idx_q     <= wrap ? 3'd0 : idx_q + 3'd1;
                started_q <= 1'b1;
                if (blink_cnt_q == BLINK_MAX) begin
                    blink_cnt_q <= '0;
                    blink_q     <= ~blink_q;
                end else begin
                    blink_cnt_q <= blink_cnt_q + BW'(1);
                end
            end
            if (wrap) begin
                snap_h_q    <= hours;
                snap_m_q    <= minutes;
                snap_s_q    <= seconds;
                snap_mode_q <= Mode24t12;
                snap_edit_q <= EditMode;
                snap_pos_q  <= EditPos;
                snap_scr_q  <= screen;
            end
            seg <= seg_d;
            an  <= an_d;
            pm  <= pm_d;
        end
    end

endmodule

// File: tb/tb_time_display_scan.sv
// Randomized self-checking bench for time_display_scan against a frame-level
// model of what each digit should show for a given scan tick.
module tb_time_display_scan;

    localparam int SD = 4;
    localparam int BT = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] hours = '0;
    logic [5:0] minutes = '0, seconds = '0;
    logic       Mode24t12 = 1'b0, EditMode = 1'b0;
    logic [2:0] EditPos = '0;
    logic [1:0] screen = '0;
    logic [6:0] seg;
    logic [5:0] an;
    logic       pm, frame_start;

    int n_vec = 0;
    int n_err = 0;
    int cyc;

    typedef struct {
        int h, m, s, mode, edit, pos, scr;
    } snap_t;

    localparam logic [6:0] SEG_TBL [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                            7'b0000000, 7'b0010000};

    time_display_scan #(.SCAN_DIV(SD), .BLINK_TICKS(BT)) dut (
        .clk(clk), .reset(reset), .hours(hours), .minutes(minutes), .seconds(seconds),
        .Mode24t12(Mode24t12), .EditMode(EditMode), .EditPos(EditPos), .screen(screen),
        .seg(seg), .an(an), .pm(pm), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Rising edges since reset released; tick k lands on edge k*SD.
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    function automatic snap_t cur_snap();
        snap_t sn;
        sn.h = int'(hours); sn.m = int'(minutes); sn.s = int'(seconds);
        sn.mode = int'(Mode24t12); sn.edit = int'(EditMode);
        sn.pos = int'(EditPos); sn.scr = int'(screen);
        return sn;
    endfunction

    // Expected {pm, an, seg} while the digit driven by scan tick k is on show.
    function automatic logic [13:0] model(snap_t sn, int k);
        int ch[6];
        int d, dh, c;
        logic p, hide;
        logic [5:0] a;
        if (k == 0) return {1'b0, 6'h3f, 7'h7f};
        d    = (k - 1) % 6;
        hide = ((k / BT) % 2) == 1;
        p    = (sn.mode == 1) && sn.h >= 12 && sn.h <= 23;
        if (sn.h > 23) begin
            ch[0] = 10; ch[1] = 10;
        end else begin
            dh = (sn.mode == 1) ? ((sn.h % 12 == 0) ? 12 : sn.h % 12) : sn.h;
            ch[0] = (sn.mode == 1 && dh < 10) ? -1 : dh / 10;
            ch[1] = dh % 10;
        end
        ch[2] = (sn.m > 59) ? 10 : sn.m / 10;
        ch[3] = (sn.m > 59) ? 10 : sn.m % 10;
        ch[4] = (sn.s > 59) ? 10 : sn.s / 10;
        ch[5] = (sn.s > 59) ? 10 : sn.s % 10;
        c = ch[d];
        if (sn.scr != 0) c = -1;
        if (sn.edit == 1 && hide && (sn.pos == d || (sn.pos == 7 && d < 2))) c = -1;
        if (c < 0) return {p, 6'h3f, 7'h7f};
        a = 6'h3f & ~(6'd1 << d);
        return {p, a, (c == 10) ? 7'b0111111 : SEG_TBL[c]};
    endfunction

    function automatic logic fs_model(int n);
        return (n > 0) && (n % SD == 0) && (((n / SD) - 1) % 6 == 0);
    endfunction

    task automatic apply(int h, int m, int s, int mode, int edit, int pos, int scr);
        hours = 5'(h); minutes = 6'(m); seconds = 6'(s);
        Mode24t12 = 1'(mode); EditMode = 1'(edit); EditPos = 3'(pos); screen = 2'(scr);
    endtask

    task automatic sync_frame(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_start !== 1'b1 && n < 40);
        n_vec++;
        if (frame_start !== 1'b1) begin
            n_err++;
            $display("FAIL %s sync: frame_start=%b after %0d cycles, want 1 within 40",
                     name, frame_start, n);
        end
    endtask

    task automatic test_reset();
        logic [13:0] exp;
        snap_t sn;
        apply(7, 5, 9, 0, 0, 0, 0);
        #1 reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if ({pm, an, seg} !== {1'b0, 6'h3f, 7'h7f} || frame_start !== 1'b0) begin
                n_err++;
                $display("FAIL reset_hold: got pm=%b an=%b seg=%b fs=%b, want 0 111111 1111111 0",
                         pm, an, seg, frame_start);
            end
        end
        reset = 1'b0;
        sn = cur_snap();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            exp = model(sn, (cyc - 1) / SD);
            n_vec++;
            if ({pm, an, seg} !== exp || frame_start !== fs_model(cyc)) begin
                n_err++;
                $display("FAIL first_frame cyc=%0d: got pm=%b an=%b seg=%b fs=%b, want %b %b %b %b",
                         cyc, pm, an, seg, frame_start, exp[13], exp[12:7], exp[6:0],
                         fs_model(cyc));
            end
        end
    endtask

    // Stimulus row f: fixed corner cases first, then random formats.
    task automatic format_vec(int f);
        int m = $urandom_range(0, 59), s = $urandom_range(0, 59);
        case (f)
            0: apply(7, 5, 9, 0, 0, 0, 0);
            1: apply(0, m, s, 1, 0, 0, 0);
            2: apply(12, m, s, 1, 0, 0, 0);
            3: apply(13, m, s, 1, 0, 0, 0);
            4: apply(23, m, s, 1, 0, 0, 0);
            5: apply(26, 60, s, $urandom_range(0, 1), 0, 0, 0);
            6: apply($urandom_range(24, 31), m, $urandom_range(60, 63), 0, 0, 0, 0);
            default: apply($urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63),
                           $urandom_range(0, 1), 0, 0, 0);
        endcase
    endtask

    task automatic test_formats();
        logic [13:0] exp;
        snap_t sn;
        format_vec(0);
        sync_frame("formats");
        for (int f = 0; f < 12; f++) begin
            sn = cur_snap();
            for (int j = 0; j < 24; j++) begin
                @(negedge clk);
                if (j == 10) format_vec(f + 1);
                exp = model(sn, (cyc - 1) / SD);
                n_vec++;
                if ({pm, an, seg} !== exp || frame_start !== fs_model(cyc)) begin
                    n_err++;
                    $display("FAIL format h=%0d m=%0d s=%0d 12h=%0d cyc=%0d: got pm=%b an=%b seg=%b fs=%b, want %b %b %b %b",
                             sn.h, sn.m, sn.s, sn.mode, cyc, pm, an, seg, frame_start,
                             exp[13], exp[12:7], exp[6:0], fs_model(cyc));
                end
            end
        end
    endtask

    task automatic test_blink();
        logic [13:0] exp;
        snap_t sn;
        apply(15, 34, 27, 0, 1, 3, 0);
        sync_frame("blink");
        for (int f = 0; f < 8; f++) begin
            sn = cur_snap();
            for (int j = 0; j < 24; j++) begin
                @(negedge clk);
                if (j == 10 && f >= 3)
                    apply($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59),
                          $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7), 0);
                exp = model(sn, (cyc - 1) / SD);
                n_vec++;
                if ({pm, an, seg} !== exp || frame_start !== fs_model(cyc)) begin
                    n_err++;
                    $display("FAIL blink edit=%0d pos=%0d cyc=%0d: got pm=%b an=%b seg=%b fs=%b, want %b %b %b %b",
                             sn.edit, sn.pos, cyc, pm, an, seg, frame_start,
                             exp[13], exp[12:7], exp[6:0], fs_model(cyc));
                end
            end
        end
    endtask

    // Mid-frame hour change, then a hidden-screen frame, then back to the clock screen.
    task automatic test_back_to_back();
        logic [13:0] exp;
        snap_t sn;
        apply(9, 41, 3, 0, 0, 0, 0);
        sync_frame("back_to_back");
        for (int f = 0; f < 4; f++) begin
            sn = cur_snap();
            for (int j = 0; j < 24; j++) begin
                @(negedge clk);
                if (f == 0 && j == 6) hours = 5'd10;
                if (f == 1 && j == 12) screen = 2'($urandom_range(1, 3));
                if (f == 2 && j == 12) screen = 2'd0;
                exp = model(sn, (cyc - 1) / SD);
                n_vec++;
                if ({pm, an, seg} !== exp || frame_start !== fs_model(cyc)) begin
                    n_err++;
                    $display("FAIL b2b frame=%0d h=%0d scr=%0d cyc=%0d: got pm=%b an=%b seg=%b fs=%b, want %b %b %b %b",
                             f, sn.h, sn.scr, cyc, pm, an, seg, frame_start,
                             exp[13], exp[12:7], exp[6:0], fs_model(cyc));
                end
            end
        end
    endtask

    task automatic test_reset_midscan();
        logic [13:0] exp;
        snap_t sn;
        int n;
        apply(18, 22, 47, 1, 0, 0, 0);
        sync_frame("reset_midscan");
        repeat (9) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        n_vec++;
        if ({pm, an, seg} !== {1'b0, 6'h3f, 7'h7f} || frame_start !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async: got pm=%b an=%b seg=%b fs=%b, want 0 111111 1111111 0",
                     pm, an, seg, frame_start);
        end
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_start !== 1'b1 && n < 40);
        n_vec++;
        if (n !== SD) begin
            n_err++;
            $display("FAIL reset_restart: first frame_start after %0d cycles, want %0d", n, SD);
        end
        sn = cur_snap();
        for (int j = 0; j < 24; j++) begin
            @(negedge clk);
            exp = model(sn, (cyc - 1) / SD);
            n_vec++;
            if ({pm, an, seg} !== exp || frame_start !== fs_model(cyc)) begin
                n_err++;
                $display("FAIL after_reset cyc=%0d: got pm=%b an=%b seg=%b fs=%b, want %b %b %b %b",
                         cyc, pm, an, seg, frame_start, exp[13], exp[12:7], exp[6:0],
                         fs_model(cyc));
            end
        end
    endtask

    initial begin
        test_reset();
        test_formats();
        test_blink();
        test_back_to_back();
        test_reset_midscan();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
